macc_chan: RTL
==============

MACC_CHAN -- requirements
Module: macc_chan

Interface
REQ-001 The module SHALL have parameter SIZEIN, default 16, signed sample width.
REQ-002 The module SHALL have parameter SIZEOUT, default 40, accumulator/output width (SIZEOUT >= SIZEIN+COEFW).
REQ-003 The module SHALL have parameter COEFW, default 8, signed coefficient width.
REQ-004 The module SHALL have parameter NCH, default 4, channel count (>= 2); CHW = clog2(NCH).
REQ-005 The module SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 The module SHALL have port ce, input, 1: pipeline enable.
REQ-008 The module SHALL have port in_valid, input, 1: sample present.
REQ-009 The module SHALL have port in_ch, input, CHW: channel of the sample.
REQ-010 The module SHALL have port sload, input, 1: start a new accumulation for in_ch.
REQ-011 The module SHALL have port a, input signed, SIZEIN: sample.
REQ-012 The module SHALL have port coef_we, input, 1: coefficient write strobe.
REQ-013 The module SHALL have port coef_ch, input, CHW: channel whose coefficient is written.
REQ-014 The module SHALL have port coef_wdata, input signed, COEFW: new coefficient.
REQ-015 The module SHALL have port out_valid, output, 1: result present.
REQ-016 The module SHALL have port out_ch, output, CHW: channel of the result.
REQ-017 The module SHALL have port accum_out, output signed, SIZEOUT: updated accumulator value.
REQ-018 The module SHALL have port out_sat, output, 1: the result was clamped.

Function
REQ-019 The module SHALL use a 3-stage pipeline: S1 captures a, in_ch, sload, in_valid and coef[in_ch]; S2 registers the full-precision signed product a*coef; S3 updates acc[ch] and the output registers.
REQ-020 Latency SHALL be exactly 3 enabled edges: a sample accepted on edge N appears on out_valid/accum_out after edge N+2.
REQ-021 S3 SHALL set acc[ch] <= product when sload=1, else acc[ch] + product (sign-extended to SIZEOUT); accum_out carries the same new value.
REQ-022 Back-to-back samples on the same channel SHALL accumulate correctly with no bubbles and no stalls.
REQ-023 Stages carrying in_valid=0 SHALL leave every acc[] unchanged; out_valid then deasserts and accum_out/out_ch/out_sat hold their last values.
REQ-024 With ce=0, all pipeline registers, acc[] and the outputs SHALL hold; out_valid stays at its held value.
REQ-025 Coefficient writes SHALL take effect on the edge where coef_we=1, independent of ce.
REQ-026 A sample accepted on the same edge as a write to its channel SHALL use the old coefficient.
REQ-027 Accumulators of different channels SHALL be fully independent.

Reset
REQ-028 While rst_n=0, the module SHALL clear all pipeline valids, out_valid, out_sat, out_ch, accum_out and acc[] to 0, and set every coef[] to 29.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight samples; the first enabled edge after deassertion accepts new input.

Configuration
REQ-030 With macro MACC_CHAN_SAT_EN defined, S3 SHALL clamp an overflowing sum to +(2^(SIZEOUT-1)-1) or -2^(SIZEOUT-1), store the clamped value in acc[ch], and assert out_sat with that result.
REQ-031 Without MACC_CHAN_SAT_EN, the sum SHALL wrap modulo 2^SIZEOUT and out_sat SHALL be constant 0.

Verification
REQ-032 The bench SHALL check: after reset, ce=1, ch0 a=3 sload=1 -> 3 edges later out_valid=1, out_ch=0, accum_out=87; then a=2 sload=0 -> accum_out=145.
REQ-033 The bench SHALL check: interleaved ch0 a=1 (sload), ch1 a=1 (sload), ch0 a=1, ch1 a=1 on consecutive edges -> 29, 29, 58, 58 with out_ch 0, 1, 0, 1.
REQ-034 The bench SHALL check: coef_we ch2 = -5 on the same edge as ch2 a=4 sload -> result 116; the next ch2 a=4 -> 116-20 = 96.
REQ-035 The bench SHALL check, with SIZEOUT=24 and coef=127: three accumulates of a=32767 -> 4161409, 8322818, then 8388607 with out_sat=1 (SAT_EN) or -4292989 with out_sat=0 (no macro).
REQ-036 The bench SHALL check: ce held low for 5 cycles mid-stream -> outputs and acc[] frozen; results resume unchanged and in order after ce returns high.
REQ-037 The bench SHALL check: rst_n pulsed low with 2 samples in flight -> no out_valid afterwards; acc[] reads 0 and coef[] reads 29 on the next sload-free sample (ch0 a=1 -> 29).

Source files
------------

// File: rtl/macc_chan.sv
// Multi-channel signed multiply-accumulate: 3-stage pipeline with per-channel coefficients and accumulators.
// Define MACC_CHAN_SAT_EN to clamp overflowing sums (out_sat flags them); otherwise sums wrap and out_sat is 0.
module macc_chan #(
  parameter int SIZEIN  = 16,
  parameter int SIZEOUT = 40,
  parameter int COEFW   = 8,
  parameter int NCH     = 4,
  localparam int CHW    = $clog2(NCH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ce,
  input  logic                      in_valid,
  input  logic [CHW-1:0]            in_ch,
  input  logic                      sload,
  input  logic signed [SIZEIN-1:0]  a,
  input  logic                      coef_we,
  input  logic [CHW-1:0]            coef_ch,
  input  logic signed [COEFW-1:0]   coef_wdata,
  output logic                      out_valid,
  output logic [CHW-1:0]            out_ch,
  output logic signed [SIZEOUT-1:0] accum_out,
  output logic                      out_sat
);

  localparam int PW = SIZEIN + COEFW;

  logic                      s1_valid_q, s1_valid_d;
  logic                      s1_sload_q, s1_sload_d;
  logic [CHW-1:0]            s1_ch_q, s1_ch_d;
  logic signed [SIZEIN-1:0]  s1_a_q, s1_a_d;
  logic signed [COEFW-1:0]   s1_coef_q, s1_coef_d;

  logic                      s2_valid_q, s2_valid_d;
  logic                      s2_sload_q, s2_sload_d;
  logic [CHW-1:0]            s2_ch_q, s2_ch_d;
  logic signed [PW-1:0]      s2_prod_q, s2_prod_d;

  logic                      out_valid_q, out_valid_d;
  logic [CHW-1:0]            out_ch_q, out_ch_d;
  logic signed [SIZEOUT-1:0] out_acc_q, out_acc_d;

  logic signed [COEFW-1:0]   coef_q [NCH];
  logic signed [COEFW-1:0]   coef_d [NCH];
  logic signed [SIZEOUT-1:0] acc_q [NCH];
  logic signed [SIZEOUT-1:0] acc_d [NCH];

  logic signed [SIZEOUT-1:0] prod_ext;
  logic signed [SIZEOUT-1:0] acc_base;
  logic signed [SIZEOUT-1:0] new_acc;
  logic                      new_sat;

`ifdef MACC_CHAN_SAT_EN
  logic                      out_sat_q, out_sat_d;
  logic [SIZEOUT:0]          sum_full;

  // One guard bit catches overflow: the two top bits differ only when the true sum is out of range.
  always_comb begin
    prod_ext = SIZEOUT'(s2_prod_q);
    acc_base = s2_sload_q ? '0 : acc_q[s2_ch_q];
    sum_full = {acc_base[SIZEOUT-1], acc_base} + {prod_ext[SIZEOUT-1], prod_ext};
    new_sat  = sum_full[SIZEOUT] ^ sum_full[SIZEOUT-1];
    if (!new_sat)
      new_acc = sum_full[SIZEOUT-1:0];
    else if (sum_full[SIZEOUT])
      new_acc = {1'b1, {(SIZEOUT-1){1'b0}}};
    else
      new_acc = {1'b0, {(SIZEOUT-1){1'b1}}};
  end

  assign out_sat = out_sat_q;
`else
  always_comb begin
    prod_ext = SIZEOUT'(s2_prod_q);
    acc_base = s2_sload_q ? '0 : acc_q[s2_ch_q];
    new_acc  = acc_base + prod_ext;
    new_sat  = 1'b0;
  end

  assign out_sat = new_sat & 1'b0;
`endif

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sload_d  = s1_sload_q;
    s1_ch_d     = s1_ch_q;
    s1_a_d      = s1_a_q;
    s1_coef_d   = s1_coef_q;
    s2_valid_d  = s2_valid_q;
    s2_sload_d  = s2_sload_q;
    s2_ch_d     = s2_ch_q;
    s2_prod_d   = s2_prod_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_acc_d   = out_acc_q;
`ifdef MACC_CHAN_SAT_EN
    out_sat_d   = out_sat_q;
`endif
    for (int unsigned i = 0; i < NCH; i++) begin
      coef_d[i] = coef_q[i];
      acc_d[i]  = acc_q[i];
    end

    // Coefficient writes bypass ce; S1 samples coef_q so a same-edge write is seen only by later samples.
    if (coef_we)
      coef_d[coef_ch] = coef_wdata;

    if (ce) begin
      s1_valid_d  = in_valid;
      s1_sload_d  = sload;
      s1_ch_d     = in_ch;
      s1_a_d      = a;
      s1_coef_d   = coef_q[in_ch];
      s2_valid_d  = s1_valid_q;
      s2_sload_d  = s1_sload_q;
      s2_ch_d     = s1_ch_q;
      s2_prod_d   = PW'(s1_a_q) * PW'(s1_coef_q);
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        acc_d[s2_ch_q] = new_acc;
        out_ch_d       = s2_ch_q;
        out_acc_d      = new_acc;
`ifdef MACC_CHAN_SAT_EN
        out_sat_d      = new_sat;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sload_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_a_q      <= '0;
      s1_coef_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_sload_q  <= 1'b0;
      s2_ch_q     <= '0;
      s2_prod_q   <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_acc_q   <= '0;
`ifdef MACC_CHAN_SAT_EN
      out_sat_q   <= 1'b0;
`endif
      for (int unsigned i = 0; i < NCH; i++) begin
        coef_q[i] <= COEFW'(29);
        acc_q[i]  <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sload_q  <= s1_sload_d;
      s1_ch_q     <= s1_ch_d;
      s1_a_q      <= s1_a_d;
      s1_coef_q   <= s1_coef_d;
      s2_valid_q  <= s2_valid_d;
      s2_sload_q  <= s2_sload_d;
      s2_ch_q     <= s2_ch_d;
      s2_prod_q   <= s2_prod_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_acc_q   <= out_acc_d;
`ifdef MACC_CHAN_SAT_EN
      out_sat_q   <= out_sat_d;
`endif
      for (int unsigned i = 0; i < NCH; i++) begin
        coef_q[i] <= coef_d[i];
        acc_q[i]  <= acc_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign accum_out = out_acc_q;

endmodule
